// File: rtl/mat_mul_stream_pkg.sv
// mat_mul_pkg
//   Shared definitions for the streaming matrix multiplier:
//   - controller state encoding (IDLE, CALC, OUT)
//   - CALC pipeline drain length
//   - OUT read prefetch latency
//   - saturation bound helpers
//   No ports (package).
package mat_mul_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    localparam int CALC_DRAIN   = 3;
    localparam int OUT_PREFETCH = 2;

    // Bounds are returned as 64-bit signed values, so data widths up to 62 bits work.
    function automatic longint sat_hi(input bit is_signed, input int dw);
        return is_signed ? (longint'(1) << (dw - 1)) - 1 : (longint'(1) << dw) - 1;
    endfunction

    function automatic longint sat_lo(input bit is_signed, input int dw);
        return is_signed ? -(longint'(1) << (dw - 1)) : longint'(0);
    endfunction

endpackage

// File: rtl/mat_mul_stream_if.sv
// mat_mul_stream_if
//   AXI-Stream bundle used for both the element input and the result output.
//   Signals: tvalid, tready, tdata[DATA_WIDTH], tstrb[DATA_WIDTH/8], tlast.
//   master modport drives valid/data/strb/last; slave modport drives ready.
//   The slave side carries no tstrb: every input byte is taken as valid.
interface mat_mul_stream_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      tvalid;
    logic                      tready;
    logic [DATA_WIDTH-1:0]     tdata;
    logic [DATA_WIDTH/8-1:0]   tstrb;
    logic                      tlast;

    modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/mm_bram_sp.sv
// mm_bram_sp
//   Synchronous single-port RAM, write-first, 1-cycle read latency.
//   Ports: clk, we (write enable), addr[DEPTH_LOG], wdata[WIDTH], rdata[WIDTH].
//   Contents are not reset.
module mm_bram_sp #(
    parameter int DEPTH_LOG = 2,
    parameter int WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [DEPTH_LOG-1:0] addr,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata
);
    logic [WIDTH-1:0] mem [0:(1 << DEPTH_LOG) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/mat_mul_stream.sv
// mat_mul_stream
//   Loads DIM x DIM matrices A and B over an AXI-Stream slave (sel picks the
//   target per frame), computes R = A x B on a rising start edge with a
//   pipelined MAC, then streams R row-major on an AXI-Stream master.
//   Ports:
//     s00_axi_aclk / s00_axi_aresetn  clock, async active-low reset
//     s00_axis  (slave)   element input, tlast marks the end of a matrix frame
//     m00_axis  (master)  result output, tlast on R[SIZE-1], tstrb all ones
//     sel    frame target (0 = A, 1 = B), sampled on the first beat of a frame
//     start  level input; a rising edge requests a compute
//     busy   high while computing or streaming results
//     done   one-cycle pulse after the last result beat is accepted
//     err_len sticky frame-length error, cleared by reset only
module mat_mul_stream
    import mat_mul_pkg::*;
#(
    parameter int DIM_LOG    = 2,
    parameter int DIM        = 2 ** DIM_LOG,
    parameter int SIZE       = DIM * DIM,
    parameter int SIZE_LOG   = 2 * DIM_LOG,
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH + DIM_LOG,
    parameter int SIGNED     = 0,
    parameter int SATURATE   = 0
) (
    input  logic             s00_axi_aclk,
    input  logic             s00_axi_aresetn,
    mat_mul_stream_if.slave  s00_axis,
    mat_mul_stream_if.master m00_axis,
    input  logic             sel,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err_len
);
    localparam int CALC_LEN = SIZE * DIM;
    localparam int CW       = 3 * DIM_LOG + 1;
    localparam logic signed [ACC_WIDTH:0] SAT_HI = (ACC_WIDTH + 1)'(sat_hi(SIGNED != 0, DATA_WIDTH));
    localparam logic signed [ACC_WIDTH:0] SAT_LO = (ACC_WIDTH + 1)'(sat_lo(SIGNED != 0, DATA_WIDTH));

    logic [1:0]            state;
    logic                  rdy_en, start_q, loaded_a, loaded_b, in_frame, sel_lat;
    logic [SIZE_LOG-1:0]   wcnt;
    logic [CW-1:0]         calc_cnt;
    logic                  s_beat, sel_eff, go_calc, issue;
    logic [DIM_LOG-1:0]    k_i, c_i, r_i;
    logic [DATA_WIDTH-1:0] ram_a_q, ram_b_q, ram_r_q, r_wdata;
    logic [SIZE_LOG-1:0]   addr_a, addr_b, addr_r;
    logic                  r_we;

    // MAC pipeline: stage 1 aligns with RAM data, stage 2 holds the product.
    logic                  v1, first1, last1, v2, first2, last2;
    logic [SIZE_LOG-1:0]   rc1, rc2;
    logic signed [ACC_WIDTH-1:0] a_ext, b_ext, prod_q, acc_q, acc_next;
    logic signed [ACC_WIDTH:0]   acc_ext;

    // Output side: registered head entry plus a one-entry skid buffer.
    logic [SIZE_LOG:0]     rd_cnt;
    logic                  rd_v, rd_last_q, rd_issue, accept;
    logic                  o_valid, o_last, s_valid, s_last;
    logic [DATA_WIDTH-1:0] o_data, s_data;
    logic [1:0]            occ;

    assign s00_axis.tready = rdy_en && (state == ST_IDLE);
    assign s_beat   = s00_axis.tvalid && s00_axis.tready;
    assign sel_eff  = in_frame ? sel_lat : sel;
    assign go_calc  = start && !start_q && (state == ST_IDLE) && loaded_a && loaded_b && (wcnt == '0);
    assign issue    = (state == ST_CALC) && (calc_cnt < CW'(CALC_LEN));
    assign k_i      = calc_cnt[DIM_LOG-1:0];
    assign c_i      = calc_cnt[2*DIM_LOG-1:DIM_LOG];
    assign r_i      = calc_cnt[3*DIM_LOG-1:2*DIM_LOG];
    assign addr_a   = (state == ST_CALC) ? {r_i, k_i} : wcnt;
    assign addr_b   = (state == ST_CALC) ? {k_i, c_i} : wcnt;
    assign r_we     = v2 && last2;
    assign addr_r   = (state == ST_CALC) ? rc2 : rd_cnt[SIZE_LOG-1:0];
    assign busy     = (state != ST_IDLE);

    assign m00_axis.tvalid = o_valid;
    assign m00_axis.tdata  = o_data;
    assign m00_axis.tlast  = o_last;
    assign m00_axis.tstrb  = '1;

    mm_bram_sp #(.DEPTH_LOG(SIZE_LOG), .WIDTH(DATA_WIDTH)) u_ram_a (
        .clk(s00_axi_aclk), .we(s_beat && !sel_eff), .addr(addr_a),
        .wdata(s00_axis.tdata), .rdata(ram_a_q));
    mm_bram_sp #(.DEPTH_LOG(SIZE_LOG), .WIDTH(DATA_WIDTH)) u_ram_b (
        .clk(s00_axi_aclk), .we(s_beat && sel_eff), .addr(addr_b),
        .wdata(s00_axis.tdata), .rdata(ram_b_q));
    mm_bram_sp #(.DEPTH_LOG(SIZE_LOG), .WIDTH(DATA_WIDTH)) u_ram_r (
        .clk(s00_axi_aclk), .we(r_we), .addr(addr_r),
        .wdata(r_wdata), .rdata(ram_r_q));

    // Frame loading, start detection and the IDLE -> CALC -> OUT sequence.
    // rdy_en keeps tready low while reset is applied and for the first cycle after.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state    <= ST_IDLE;
            rdy_en   <= 1'b0;
            start_q  <= 1'b0;
            loaded_a <= 1'b0;
            loaded_b <= 1'b0;
            in_frame <= 1'b0;
            sel_lat  <= 1'b0;
            wcnt     <= '0;
            calc_cnt <= '0;
            done     <= 1'b0;
            err_len  <= 1'b0;
        end else begin
            rdy_en  <= 1'b1;
            start_q <= start;
            done    <= 1'b0;
            if (s_beat) begin
                if (!in_frame) sel_lat <= sel;
                if (s00_axis.tlast) begin
                    in_frame <= 1'b0;
                    wcnt     <= '0;
                    if (wcnt == SIZE_LOG'(SIZE - 1)) begin
                        if (sel_eff) loaded_b <= 1'b1;
                        else         loaded_a <= 1'b1;
                    end else begin
                        err_len <= 1'b1;
                    end
                end else begin
                    in_frame <= 1'b1;
                    if (wcnt == SIZE_LOG'(SIZE - 1)) err_len <= 1'b1;
                    wcnt <= wcnt + 1'b1;
                end
            end
            case (state)
                ST_IDLE: if (go_calc) state <= ST_CALC;
                ST_CALC: begin
                    if (calc_cnt == CW'(CALC_LEN + CALC_DRAIN - 1)) begin
                        state    <= ST_OUT;
                        calc_cnt <= '0;
                    end else begin
                        calc_cnt <= calc_cnt + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (accept && o_last) begin
                        state    <= ST_IDLE;
                        done     <= 1'b1;
                        loaded_a <= 1'b0;
                        loaded_b <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Operand extension to full accumulator width; the product cannot overflow it.
    always_comb begin
        a_ext    = {{(ACC_WIDTH - DATA_WIDTH){(SIGNED != 0) && ram_a_q[DATA_WIDTH-1]}}, ram_a_q};
        b_ext    = {{(ACC_WIDTH - DATA_WIDTH){(SIGNED != 0) && ram_b_q[DATA_WIDTH-1]}}, ram_b_q};
        acc_next = first2 ? prod_q : acc_q + prod_q;
        acc_ext  = {(SIGNED != 0) && acc_next[ACC_WIDTH-1], acc_next};
        r_wdata  = acc_next[DATA_WIDTH-1:0];
        if (SATURATE != 0) begin
            if (acc_ext > SAT_HI)      r_wdata = SAT_HI[DATA_WIDTH-1:0];
            else if (acc_ext < SAT_LO) r_wdata = SAT_LO[DATA_WIDTH-1:0];
        end
    end

    // Tags travel alongside the data so the accumulator knows when to restart
    // (k == 0) and when a finished dot product must be written (k == DIM-1).
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            v1 <= 1'b0; first1 <= 1'b0; last1 <= 1'b0; rc1 <= '0;
            v2 <= 1'b0; first2 <= 1'b0; last2 <= 1'b0; rc2 <= '0;
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            v1     <= issue;
            first1 <= (k_i == '0);
            last1  <= (k_i == DIM_LOG'(DIM - 1));
            rc1    <= {r_i, c_i};
            v2     <= v1;
            first2 <= first1;
            last2  <= last1;
            rc2    <= rc1;
            prod_q <= a_ext * b_ext;
            if (v2) acc_q <= acc_next;
        end
    end

    // A read is issued only if its data is guaranteed a slot when it returns,
    // counting the head entry that leaves this cycle.
    always_comb begin
        accept   = o_valid && m00_axis.tready;
        occ      = {1'b0, o_valid} + {1'b0, s_valid} + {1'b0, rd_v};
        rd_issue = (state == ST_OUT) && (rd_cnt < (SIZE_LOG + 1)'(SIZE)) &&
                   (occ <= (accept ? 2'd2 : 2'd1));
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            rd_cnt <= '0; rd_v <= 1'b0; rd_last_q <= 1'b0;
            o_valid <= 1'b0; o_data <= '0; o_last <= 1'b0;
            s_valid <= 1'b0; s_data <= '0; s_last <= 1'b0;
        end else begin
            rd_v <= rd_issue;
            if (state != ST_OUT) rd_cnt <= '0;
            else if (rd_issue) begin
                rd_cnt    <= rd_cnt + 1'b1;
                rd_last_q <= (rd_cnt == (SIZE_LOG + 1)'(SIZE - 1));
            end
            if (accept) begin
                if (s_valid) begin
                    o_data <= s_data;
                    o_last <= s_last;
                    if (rd_v) begin
                        s_data <= ram_r_q;
                        s_last <= rd_last_q;
                    end else begin
                        s_valid <= 1'b0;
                    end
                end else if (rd_v) begin
                    o_data <= ram_r_q;
                    o_last <= rd_last_q;
                end else begin
                    o_valid <= 1'b0;
                end
            end else if (rd_v) begin
                if (!o_valid) begin
                    o_valid <= 1'b1;
                    o_data  <= ram_r_q;
                    o_last  <= rd_last_q;
                end else begin
                    s_valid <= 1'b1;
                    s_data  <= ram_r_q;
                    s_last  <= rd_last_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_mat_mul_stream.sv
// tb_mat_mul_stream
//   Self-checking bench for mat_mul_stream (2x2, 8-bit, signed, saturating).
//   Expected results come from a plain-arithmetic matrix product model.
module tb_mat_mul_stream;
    localparam int DIM_LOG  = 1;
    localparam int DIM      = 2;
    localparam int SIZE     = 4;
    localparam int DW       = 8;
    localparam int SIGNED_P = 1;
    localparam int SAT_P    = 1;
    localparam longint MASK = (longint'(1) << DW) - 1;

    typedef int mat_t [SIZE];

    logic s00_axi_aclk    = 1'b0;
    logic s00_axi_aresetn = 1'b0;
    logic sel   = 1'b0;
    logic start = 1'b0;
    logic busy, done, err_len;
    int   checks = 0;
    int   errors = 0;

    mat_mul_stream_if #(.DATA_WIDTH(DW)) s_if ();
    mat_mul_stream_if #(.DATA_WIDTH(DW)) m_if ();

    assign s_if.tstrb = '1;

    mat_mul_stream #(
        .DIM_LOG(DIM_LOG), .DATA_WIDTH(DW), .SIGNED(SIGNED_P), .SATURATE(SAT_P)
    ) dut (
        .s00_axi_aclk(s00_axi_aclk),
        .s00_axi_aresetn(s00_axi_aresetn),
        .s00_axis(s_if),
        .m00_axis(m_if),
        .sel(sel),
        .start(start),
        .busy(busy),
        .done(done),
        .err_len(err_len)
    );

    always #5 s00_axi_aclk = ~s00_axi_aclk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic longint toOperand(input int x);
        longint v;
        v = longint'(x) & MASK;
        if (SIGNED_P != 0 && v >= (longint'(1) << (DW - 1))) v = v - (longint'(1) << DW);
        return v;
    endfunction

    function automatic mat_t refModel(input mat_t a, input mat_t b);
        mat_t   res;
        longint sum, hi, lo;
        hi = (SIGNED_P != 0) ? (longint'(1) << (DW - 1)) - 1 : MASK;
        lo = (SIGNED_P != 0) ? -(longint'(1) << (DW - 1)) : 0;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                sum = 0;
                for (int k = 0; k < DIM; k++)
                    sum += toOperand(a[r*DIM+k]) * toOperand(b[k*DIM+c]);
                if (SAT_P != 0) begin
                    if (sum > hi) sum = hi;
                    if (sum < lo) sum = lo;
                end
                res[r*DIM+c] = int'(sum & MASK);
            end
        end
        return res;
    endfunction

    task automatic sendBeat(input int value, input bit last);
        int guard;
        guard = 0;
        s_if.tdata  = DW'(value);
        s_if.tlast  = last;
        s_if.tvalid = 1'b1;
        while (!s_if.tready && guard < 50) begin
            @(posedge s00_axi_aclk); #1;
            guard++;
        end
        if (guard == 50) checkOutput("s_tready_timeout", 0, 1);
        @(posedge s00_axi_aclk); #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic sendFrame(input bit which, input mat_t m, input int n);
        sel = which;
        for (int i = 0; i < n; i++) sendBeat(m[i], i == n - 1);
    endtask

    task automatic applyStimulus(input mat_t a, input mat_t b, input bit b_first);
        if (b_first) begin
            sendFrame(1'b1, b, SIZE);
            sendFrame(1'b0, a, SIZE);
        end else begin
            sendFrame(1'b0, a, SIZE);
            sendFrame(1'b1, b, SIZE);
        end
    endtask

    // mode 0: tready always high, mode 1: high one cycle in three, mode 2: random
    task automatic runCompute(input mat_t exp, input int mode);
        int          lat, beats, guard;
        logic        v, rdy, l, held_l, stalled;
        logic [DW-1:0] d, held_d;
        m_if.tready = 1'b0;
        start = 1'b1;
        @(posedge s00_axi_aclk); #1;
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1);
        lat = 0;
        while (!m_if.tvalid && lat < 100) begin
            @(posedge s00_axi_aclk); #1;
            lat++;
        end
        checkOutput("first_tvalid_latency", lat, 13);
        beats = 0; guard = 0; stalled = 1'b0; held_d = '0; held_l = 1'b0;
        while (beats < SIZE && guard < 400) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (guard % 3 == 0) : 1'($urandom_range(0, 1));
            m_if.tready = rdy;
            v = m_if.tvalid; d = m_if.tdata; l = m_if.tlast;
            if (stalled) begin
                checkOutput("stall_tvalid", v, 1);
                checkOutput("stall_tdata", d, held_d);
                checkOutput("stall_tlast", l, held_l);
            end
            @(posedge s00_axi_aclk); #1;
            guard++;
            if (v && rdy) begin
                checkOutput($sformatf("R[%0d]", beats), d, exp[beats]);
                checkOutput($sformatf("tlast[%0d]", beats), l, beats == SIZE - 1);
                beats++;
            end
            stalled = v && !rdy;
            held_d = d; held_l = l;
        end
        checkOutput("beat_count", beats, SIZE);
        checkOutput("done_pulse", done, 1);
        checkOutput("busy_after_out", busy, 0);
        m_if.tready = 1'b1;
        repeat (3) @(posedge s00_axi_aclk);
        #1;
        checkOutput("no_extra_beat", m_if.tvalid, 0);
        checkOutput("done_cleared", done, 0);
        m_if.tready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        mat_t a, b, exp;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; m_if.tready = 1'b0;
        repeat (3) @(posedge s00_axi_aclk);
        #1;
        checkOutput("rst_s_tready", s_if.tready, 0);
        checkOutput("rst_m_tvalid", m_if.tvalid, 0);
        checkOutput("rst_m_tdata", m_if.tdata, 0);
        checkOutput("rst_m_tlast", m_if.tlast, 0);
        checkOutput("rst_m_tstrb", m_if.tstrb, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err_len", err_len, 0);
        s00_axi_aresetn = 1'b1;
        @(posedge s00_axi_aclk); #1;

        $display("[TB] basic multiply");
        a = '{1, 2, 3, 4}; b = '{5, 6, 7, 8};
        applyStimulus(a, b, 1'b0);
        runCompute('{19, 22, 43, 50}, 0);

        $display("[TB] signed operands");
        a = '{-1, 2, 3, -4};
        applyStimulus(a, b, 1'b1);
        runCompute('{9, 10, 256 - 13, 256 - 14}, 0);

        $display("[TB] saturation");
        a = '{100, 100, 0, 0}; b = '{100, 0, 100, 0};
        applyStimulus(a, b, 1'b0);
        runCompute('{127, 0, 0, 0}, 0);

        $display("[TB] output backpressure");
        a = '{1, 2, 3, 4}; b = '{5, 6, 7, 8};
        applyStimulus(a, b, 1'b0);
        runCompute('{19, 22, 43, 50}, 1);

        $display("[TB] frame length error");
        sendFrame(1'b1, b, SIZE);
        sendFrame(1'b0, a, 3);
        checkOutput("err_len_set", err_len, 1);
        start = 1'b1;
        repeat (5) @(posedge s00_axi_aclk);
        #1;
        checkOutput("start_ignored_short_frame", busy, 0);
        start = 1'b0;
        @(posedge s00_axi_aclk); #1;
        sendFrame(1'b0, a, SIZE);
        runCompute('{19, 22, 43, 50}, 0);
        checkOutput("err_len_sticky", err_len, 1);

        $display("[TB] randomized products");
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < SIZE; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    a[i] = int'($urandom_range(0, 255)) - 128;
                    b[i] = int'($urandom_range(0, 255)) - 128;
                end else begin
                    a[i] = int'($urandom_range(0, 24)) - 12;
                    b[i] = int'($urandom_range(0, 24)) - 12;
                end
            end
            exp = refModel(a, b);
            applyStimulus(a, b, 1'($urandom_range(0, 1)));
            runCompute(exp, int'($urandom_range(0, 2)));
        end

        $display("[TB] reset during compute");
        a = '{1, 2, 3, 4}; b = '{5, 6, 7, 8};
        applyStimulus(a, b, 1'b0);
        start = 1'b1;
        @(posedge s00_axi_aclk); #1;
        start = 1'b0;
        repeat (4) @(posedge s00_axi_aclk);
        #1;
        s00_axi_aresetn = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_m_tvalid", m_if.tvalid, 0);
        checkOutput("midrst_err_len", err_len, 0);
        checkOutput("midrst_s_tready", s_if.tready, 0);
        repeat (2) @(posedge s00_axi_aclk);
        #1;
        s00_axi_aresetn = 1'b1;
        @(posedge s00_axi_aclk); #1;
        start = 1'b1;
        repeat (5) @(posedge s00_axi_aclk);
        #1;
        checkOutput("start_ignored_after_reset", busy, 0);
        start = 1'b0;
        @(posedge s00_axi_aclk); #1;
        a = '{2, 0, 0, 2}; b = '{3, 4, 5, 6};
        applyStimulus(a, b, 1'b1);
        runCompute(refModel(a, b), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
